fu_result_queue: RTL and testbench
==================================

// Module: fu_result_queue
// PURPOSE
//  Parametrised result queue sitting between a functional unit and the common data bus (CDB).
//  - Buffers (value, tag, exception) results in FIFO order.
//  - Requests the CDB through the cdb_arbiter and drives the shared bus only while granted.
//  - Adds over the earlier 4-entry buffer: configurable depth, occupancy/full backpressure
//    to the issuing reservation station, full-flush on misprediction, sticky overflow detection.
// PARAMETERS
//  XLEN       32  result data width
//  TAG_WIDTH  32  ROB/RS tag width
//  DEPTH      4   entries; power of two, >= 2
//  CW         $clog2(DEPTH+1)  count width (localparam)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-low
//  value          in   XLEN       FU result
//  tag            in   TAG_WIDTH  result tag
//  exception      in   1          FU raised exception for this result
//  write_en       in   1          FU result valid this cycle
//  flush          in   1          discard all entries (mispredict/exception recovery)
//  cdb_permit     in   1          arbiter grant, combinational, same cycle
//  not_empty      out  1          CDB request to arbiter
//  full           out  1          count == DEPTH; stalls issue to FU
//  almost_full    out  1          count >= DEPTH-1
//  count          out  CW         occupied entries
//  overflow       out  1          sticky: a write was dropped
//  cdb_data       out  XLEN       head value, tri-state
//  cdb_tag        out  TAG_WIDTH  head tag, tri-state
//  cdb_exception  out  1          head exception, tri-state
// BEHAVIOUR
//  - Reset (reset==0 at posedge): pointers, count, valid bits, stored fields and overflow all go to 0.
//    Resulting outputs: not_empty=0, full=0, almost_full=(DEPTH-1==0 ? 1 : 0)=0, count=0, overflow=0.
//    Reset mid-operation discards all contents; write_en/cdb_permit in that cycle are ignored.
//  - Ring buffer: rd_ptr/wr_ptr are log2(DEPTH) bits and wrap naturally at DEPTH. Entry valid bits are kept.
//  - Write: accepted iff write_en && (!full || (cdb_permit && not_empty)).
//    Store goes to wr_ptr; valid set; wr_ptr+1. Visible at the head no earlier than the next cycle
//    (no write-to-CDB bypass).
//  - Dropped write: write_en && full && !(cdb_permit && not_empty) -> entry unchanged, overflow<=1.
//    overflow stays set until reset; flush does not clear it.
//  - Read: cdb_permit && not_empty -> clear valid[rd_ptr]; rd_ptr+1 at the next edge.
//    cdb_permit while empty: no state change.
//  - CDB drive (combinational): cdb_data/cdb_tag/cdb_exception = head entry when
//    cdb_permit && not_empty, else 'z.
//  - Simultaneous write + read: both happen, count unchanged. This also applies when full,
//    and when count==1 (the new entry goes to the next slot).
//  - count: +1 on accepted write only; -1 on read only; unchanged on both or neither.
//    Never exceeds DEPTH and never underflows.
//  - full, almost_full and not_empty are decoded from registered state only: no combinational path
//    from write_en, and not_empty has no path from cdb_permit.
//  - flush: highest priority after reset. Next edge: pointers, count, valid = 0;
//    same-cycle write is discarded and not counted as overflow.
//    Same-cycle grant still drives the bus combinationally; consumers squash by their own flush.
// STRUCTURE
//  - Shared package (ooo_pkg): cdb_entry_t struct {value, tag, exception}, reused by RS/ROB CDB snoop.
//  - One sub-module: ring_ptr_ctrl #(DEPTH): rd/wr pointers, count, full/almost_full/empty
//    from push/pop/flush. Reusable by RS free lists.
//  - Top level holds the cdb_entry_t storage array, valid bits, overflow and the tri-state drivers.
// TESTING
//  1. Reset, then 3 writes (tags 1,2,3), no permit -> count=3, almost_full=1, full=0,
//     not_empty=1, cdb_* = z.
//  2. Fill DEPTH=4 (tags 1-4), write tag 5 without permit -> full=1, overflow=1, tag 5 lost;
//     drain via 4 grants -> tags 1,2,3,4 in order.
//  3. Full with write tag 9 and grant in the same cycle -> tag 1 on CDB, count stays 4,
//     overflow=0; tag 9 emerges after tags 2-4.
//  4. 10 write/read pairs with count oscillating 0/1 -> pointers wrap twice, tags emerge in order,
//     cdb_exception follows each entry.
//  5. count=3 with flush, write_en and grant in the same cycle -> next cycle count=0, not_empty=0,
//     write discarded, overflow unchanged.
//  6. reset low while count=2 and write_en=1 -> next cycle everything zero, the write is not stored;
//     a grant while empty leaves the bus at z and state unchanged.

Source files
------------

// File: rtl/ooo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ooo_pkg
//  Description : Shared out-of-order core types; CDB entry reused by RS/ROB.
//  Revision    : 1.0  initial release
// ============================================================================
package ooo_pkg;

    localparam int OOO_XLEN      = 32;
    localparam int OOO_TAG_WIDTH = 32;

    typedef struct packed {
        logic [OOO_XLEN-1:0]      value;
        logic [OOO_TAG_WIDTH-1:0] tag;
        logic                     exception;
    } cdb_entry_t;

    function automatic cdb_entry_t make_cdb_entry(
        input logic [OOO_XLEN-1:0]      value,
        input logic [OOO_TAG_WIDTH-1:0] tag,
        input logic                     exception
    );
        cdb_entry_t e;
        e.value     = value;
        e.tag       = tag;
        e.exception = exception;
        return e;
    endfunction

endpackage : ooo_pkg
`default_nettype wire

// File: rtl/fu_result_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fu_result_queue_if
//  Description : FU / arbiter / issue-side handshake of the FU result queue.
//  Revision    : 1.0  initial release
// ============================================================================
interface fu_result_queue_if
    import ooo_pkg::*;
#(
    parameter int XLEN      = OOO_XLEN,
    parameter int TAG_WIDTH = OOO_TAG_WIDTH,
    parameter int DEPTH     = 4,
    localparam int CW       = $clog2(DEPTH + 1)
);
    logic [XLEN-1:0]      value;
    logic [TAG_WIDTH-1:0] tag;
    logic                 exception;
    logic                 write_en;
    logic                 flush;
    logic                 cdb_permit;
    logic                 not_empty;
    logic                 full;
    logic                 almost_full;
    logic [CW-1:0]        count;
    logic                 overflow;

    modport master (
        output value, tag, exception, write_en, flush, cdb_permit,
        input  not_empty, full, almost_full, count, overflow
    );

    modport slave (
        input  value, tag, exception, write_en, flush, cdb_permit,
        output not_empty, full, almost_full, count, overflow
    );
endinterface : fu_result_queue_if
`default_nettype wire

// File: rtl/ring_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ring_ptr_ctrl
//  Description : Ring-buffer read/write pointers, occupancy and fill flags.
//  Revision    : 1.0  initial release
// ============================================================================
module ring_ptr_ctrl #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          push,
    input  wire logic          pop,
    input  wire logic          flush,
    output logic [PW-1:0]      rd_ptr,
    output logic [PW-1:0]      wr_ptr,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               almost_full,
    output logic               empty
);
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    // Guard locally so the counter stays in range whatever the caller does.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_ptr      = r_rd_ptr;
    assign wr_ptr      = r_wr_ptr;
    assign count       = r_count;
    assign full        = (r_count == CW'(DEPTH));
    assign almost_full = (r_count >= CW'(DEPTH - 1));
    assign empty       = (r_count == '0);
endmodule : ring_ptr_ctrl
`default_nettype wire

// File: rtl/fu_result_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fu_result_queue
//  Description : FIFO of FU results that requests and drives the shared CDB.
//  Revision    : 1.0  initial release
// ============================================================================
module fu_result_queue
    import ooo_pkg::*;
#(
    parameter int XLEN      = OOO_XLEN,
    parameter int TAG_WIDTH = OOO_TAG_WIDTH,
    parameter int DEPTH     = 4,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    fu_result_queue_if.slave          q,
    output wire [XLEN-1:0]            cdb_data,
    output wire [TAG_WIDTH-1:0]       cdb_tag,
    output wire                       cdb_exception
);
    logic [PW-1:0] w_rd_ptr;
    logic [PW-1:0] w_wr_ptr;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_almost_full;
    logic          w_empty;
    logic          w_not_empty;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    cdb_entry_t    w_head;

    cdb_entry_t       r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic             r_overflow;

    assign w_not_empty = !w_empty && r_valid[w_rd_ptr];
    assign w_grant     = q.cdb_permit && w_not_empty;

    // A write into a full queue still lands when the head leaves in the same cycle.
    assign w_push = q.write_en && !q.flush && (!w_full || w_grant);
    assign w_pop  = w_grant && !q.flush;
    assign w_drop = q.write_en && !q.flush && w_full && !w_grant;

    ring_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk         (clk),
        .reset       (reset),
        .push        (w_push),
        .pop         (w_pop),
        .flush       (q.flush),
        .rd_ptr      (w_rd_ptr),
        .wr_ptr      (w_wr_ptr),
        .count       (w_count),
        .full        (w_full),
        .almost_full (w_almost_full),
        .empty       (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (q.flush) begin
                r_valid <= '0;
            end else begin
                // Set after clear: when full, push and pop share a slot and it must stay valid.
                if (w_pop) r_valid[w_rd_ptr] <= 1'b0;
                if (w_push) begin
                    r_mem[w_wr_ptr]   <= make_cdb_entry(OOO_XLEN'(q.value),
                                                        OOO_TAG_WIDTH'(q.tag),
                                                        q.exception);
                    r_valid[w_wr_ptr] <= 1'b1;
                end
            end
        end
    end

    assign w_head = r_mem[w_rd_ptr];

    assign cdb_data      = w_grant ? XLEN'(w_head.value)    : {XLEN{1'bz}};
    assign cdb_tag       = w_grant ? TAG_WIDTH'(w_head.tag) : {TAG_WIDTH{1'bz}};
    assign cdb_exception = w_grant ? w_head.exception       : 1'bz;

    assign q.not_empty   = w_not_empty;
    assign q.full        = w_full;
    assign q.almost_full = w_almost_full;
    assign q.count       = w_count;
    assign q.overflow    = r_overflow;
endmodule : fu_result_queue
`default_nettype wire

// File: tb/tb_fu_result_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fu_result_queue
//  Description : Directed and random checks of fu_result_queue against a queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fu_result_queue;
    import ooo_pkg::*;

    localparam int XLEN      = 32;
    localparam int TAG_WIDTH = 32;
    localparam int DEPTH     = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fu_result_queue_if #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) bus ();

    wire [XLEN-1:0]      cdb_data;
    wire [TAG_WIDTH-1:0] cdb_tag;
    wire                 cdb_exception;

    fu_result_queue #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .q             (bus),
        .cdb_data      (cdb_data),
        .cdb_tag       (cdb_tag),
        .cdb_exception (cdb_exception)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    cdb_entry_t model_q[$];
    logic       model_ovf   = 1'b0;
    logic       model_known = 1'b0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
        end
    endtask

    // Released bus reads as all-z, or as zero on a two-state simulator.
    function automatic logic bus_released();
        return ((cdb_tag === '0) || (cdb_tag === {TAG_WIDTH{1'bz}})) &&
               ((cdb_data === '0) || (cdb_data === {XLEN{1'bz}}));
    endfunction

    task automatic check_outputs(input logic permit);
        int n = model_q.size();
        check("count",       64'(bus.count),     64'(n));
        check("full",        64'(bus.full),      64'(n == DEPTH));
        check("almost_full", 64'(bus.almost_full), 64'(n >= DEPTH - 1));
        check("not_empty",   64'(bus.not_empty), 64'(n > 0));
        check("overflow",    64'(bus.overflow),  64'(model_ovf));
        if (permit && n > 0) begin
            check("cdb_tag",       64'(cdb_tag),       64'(model_q[0].tag));
            check("cdb_data",      64'(cdb_data),      64'(model_q[0].value));
            check("cdb_exception", 64'(cdb_exception), 64'(model_q[0].exception));
        end else begin
            check("cdb_released", 64'(bus_released()), 64'(1));
        end
    endtask

    // One clock: drive in the low phase, check pre-edge outputs, then advance the model.
    task automatic step(input logic rst_n, input logic we, input logic fl, input logic permit,
                        input logic [TAG_WIDTH-1:0] tg, input logic [XLEN-1:0] val,
                        input logic exc);
        int  n;
        logic granted, accepted;
        reset          = rst_n;
        bus.write_en   = we;
        bus.flush      = fl;
        bus.cdb_permit = permit;
        bus.tag        = tg;
        bus.value      = val;
        bus.exception  = exc;
        #2;
        if (model_known) check_outputs(permit);
        @(posedge clk);
        n = model_q.size();
        if (!rst_n) begin
            model_q.delete();
            model_ovf   = 1'b0;
            model_known = 1'b1;
        end else if (fl) begin
            model_q.delete();
        end else begin
            granted  = permit && (n > 0);
            accepted = we && ((n < DEPTH) || granted);
            if (we && !accepted) model_ovf = 1'b1;
            if (granted)  void'(model_q.pop_front());
            if (accepted) model_q.push_back(make_cdb_entry(val, tg, exc));
        end
        @(negedge clk);
    endtask

    task automatic wr(input int t);
        step(1, 1, 0, 0, TAG_WIDTH'(t), XLEN'(32'hA000_0000 | t), t[0]);
    endtask

    task automatic grant();
        step(1, 0, 0, 1, '0, '0, 1'b0);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, '0, '0, 1'b0);
        step(0, 0, 0, 0, '0, '0, 1'b0);
    endtask

    initial begin
        bus.write_en   = 1'b0;
        bus.flush      = 1'b0;
        bus.cdb_permit = 1'b0;
        bus.tag        = '0;
        bus.value      = '0;
        bus.exception  = 1'b0;
        @(negedge clk);
        do_reset();
        idle();

        // Three writes, no grant: almost full, bus released.
        for (int t = 1; t <= 3; t++) wr(t);
        idle();

        // Fill, drop tag 5, drain in order.
        wr(4);
        wr(5);
        idle();
        for (int i = 0; i < 4; i++) grant();
        idle();

        // Full with simultaneous write and grant.
        do_reset();
        for (int t = 1; t <= 4; t++) wr(t);
        step(1, 1, 0, 1, TAG_WIDTH'(9), XLEN'(32'hA000_0009), 1'b1);
        for (int i = 0; i < 5; i++) grant();
        idle();

        // Count oscillating 0/1 so the pointers wrap.
        for (int t = 10; t < 20; t++) begin
            wr(t);
            grant();
        end
        idle();

        // Flush with write and grant in the same cycle.
        for (int t = 21; t <= 23; t++) wr(t);
        step(1, 1, 1, 1, TAG_WIDTH'(24), XLEN'(32'hA000_0018), 1'b0);
        idle();

        // Reset mid-operation with a write pending, then a grant while empty.
        wr(30);
        wr(31);
        step(0, 1, 0, 1, TAG_WIDTH'(32), XLEN'(32'hA000_0020), 1'b0);
        grant();
        idle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic r_n, w, f, p;
            r_n = ($urandom_range(0, 199) != 0);
            f   = ($urandom_range(0, 19) == 0);
            w   = ($urandom_range(0, 9) < 6);
            p   = ($urandom_range(0, 1) == 1);
            step(r_n, w, f, p, TAG_WIDTH'($urandom | 1), XLEN'($urandom | 1),
                 1'($urandom_range(0, 1)));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule : tb_fu_result_queue
`default_nettype wire
